assert_cnt_reader: RTL and testbench

//  Initiator side of the assertion-counter read port (cnt_req/cnt_addr/cnt_ack/cnt_data).
//  It sweeps NUM_CNT counter addresses in the assertion region and stores each returned

---
 rtl/assert_cnt_reader.sv | 141 ++++++++++++++
 tb/tb_assert_cnt_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/assert_cnt_reader.sv
`default_nettype none
// ============================================================================
//  Module      : assert_cnt_reader
//  Description : Initiator for the assertion-counter read port. It sweeps
//                NUM_CNT counter addresses, captures each returned value (or
//                a timeout pattern) into a snapshot RAM, and serves the frozen
//                snapshot through a registered host read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module assert_cnt_reader #(
  parameter int          NUM_CNT     = 16,
  parameter int          SNAP_AW     = 4,
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter logic [31:0] ADDR_STRIDE = 32'h4,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] TMO_PATTERN = 32'hDEADBEEF
) (
  input  logic               assert_clk,
  input  logic               assert_rst,
  input  logic               start,
  input  logic               assertion_failed,
  output logic               cnt_req,
  output logic [31:0]        cnt_addr,
  input  logic               cnt_ack,
  input  logic [31:0]        cnt_data,
  input  logic [SNAP_AW-1:0] snap_raddr,
  output logic [31:0]        snap_rdata,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic               fail_latched
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int                 SNAP_DEPTH = 1 << SNAP_AW;
  localparam logic [SNAP_AW-1:0] LAST_IDX   = SNAP_AW'(NUM_CNT - 1);
  localparam logic [15:0]        TMO_LAST   = 16'(TIMEOUT - 1);

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [SNAP_AW-1:0] idx;
  logic [15:0]        tmo_cnt;
  logic               fail_q;
  logic               snap_we;
  logic [31:0]        snap_mem [SNAP_DEPTH];

  // A sweep is launched by software or by the first cycle of a failure.
  logic fail_rise;
  logic launch;
  logic tmo_hit;
  logic rd_done;
  logic last_cnt;

  assign fail_rise = assertion_failed & ~fail_q;
  assign launch    = start | fail_rise;
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign rd_done   = cnt_ack | tmo_hit;
  assign last_cnt  = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge assert_clk) begin
    if (assert_rst) state <= S_IDLE;
    else            state <= next_state;
  end

  // Next-state decode: a read completes on ack or on the final timeout cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (launch) next_state = S_REQ;
      S_REQ:   if (rd_done) next_state = last_cnt ? S_DONE : S_GAP;
      S_GAP:   next_state = S_REQ;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so they are glitch-free.
  always_comb begin
    cnt_req = (state == S_REQ);
    done    = (state == S_DONE);
    busy    = (state != S_IDLE);
    snap_we = (state == S_REQ) && rd_done;
  end

  // Sweep bookkeeping: index, address, timeout counter and status flags.
  always_ff @(posedge assert_clk) begin
    if (assert_rst) begin
      idx          <= '0;
      tmo_cnt      <= '0;
      timeout_err  <= 1'b0;
      cnt_addr     <= '0;
      fail_q       <= 1'b0;
      fail_latched <= 1'b0;
    end else begin
      fail_q <= assertion_failed;
      if (assertion_failed) fail_latched <= 1'b1;
      case (state)
        S_IDLE: begin
          if (launch) begin
            idx         <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            cnt_addr    <= ADDR_BASE;
          end
        end
        S_REQ: begin
          if (rd_done) begin
            tmo_cnt <= '0;
            // An ack arriving in the timeout cycle still wins.
            if (!cnt_ack) timeout_err <= 1'b1;
            if (!last_cnt) begin
              idx      <= idx + SNAP_AW'(1);
              cnt_addr <= cnt_addr + ADDR_STRIDE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Snapshot RAM write; contents intentionally survive reset.
  always_ff @(posedge assert_clk) begin
    if (snap_we) snap_mem[idx] <= cnt_ack ? cnt_data : TMO_PATTERN;
  end

  // Registered host read; a same-cycle write to the read index returns old data.
  always_ff @(posedge assert_clk) begin
    if (assert_rst) snap_rdata <= '0;
    else            snap_rdata <= snap_mem[snap_raddr];
  end

endmodule
`default_nettype wire

// File: tb/tb_assert_cnt_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_assert_cnt_reader
//  Description : Directed self-checking bench for assert_cnt_reader with a
//                configurable counter slave and a request/gap monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_assert_cnt_reader;

  logic        assert_clk = 1'b0;
  logic        assert_rst = 1'b1;
  logic        start = 1'b0;
  logic        assertion_failed = 1'b0;
  logic        cnt_req;
  logic [31:0] cnt_addr;
  logic        cnt_ack = 1'b0;
  logic [31:0] cnt_data = 32'h0;
  logic [3:0]  snap_raddr = 4'h0;
  logic [31:0] snap_rdata;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        fail_latched;

  assert_cnt_reader #(
    .NUM_CNT(4), .SNAP_AW(4), .ADDR_BASE(32'h0), .ADDR_STRIDE(32'h4),
    .TIMEOUT(8), .TMO_PATTERN(32'hDEADBEEF)
  ) dut (
    .assert_clk(assert_clk), .assert_rst(assert_rst), .start(start),
    .assertion_failed(assertion_failed), .cnt_req(cnt_req), .cnt_addr(cnt_addr),
    .cnt_ack(cnt_ack), .cnt_data(cnt_data), .snap_raddr(snap_raddr),
    .snap_rdata(snap_rdata), .busy(busy), .done(done),
    .timeout_err(timeout_err), .fail_latched(fail_latched)
  );

  always #5 assert_clk = ~assert_clk;

  // Slave controls (written only by the stimulus block)
  int          ack_delay   = 2;
  logic [31:0] no_ack_addr = 32'hFFFF_FFFF;
  logic [31:0] data_ofs    = 32'd100;

  // Monitor records (written only by the negedge process)
  logic [31:0] addr_q[$];
  int          hold_q[$];
  int          gap_q[$];
  int          done_cnt = 0;
  int          age = 0;
  int          low_run = 0;
  bit          had_req = 0;
  bit          req_prev = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Counter slave and bus monitor, both evaluated away from the active edge.
  always @(negedge assert_clk) begin
    if (cnt_req && !assert_rst) begin
      age      = age + 1;
      cnt_ack  = (cnt_addr != no_ack_addr) && (age == ack_delay + 1);
      cnt_data = cnt_addr + data_ofs;
    end else begin
      age     = 0;
      cnt_ack = 1'b0;
    end
    if (cnt_req) begin
      if (!req_prev) begin
        addr_q.push_back(cnt_addr);
        hold_q.push_back(1);
        if (had_req && low_run > 0) gap_q.push_back(low_run);
        low_run = 0;
        had_req = 1;
      end else begin
        hold_q[hold_q.size()-1] = hold_q[hold_q.size()-1] + 1;
      end
    end else if (busy) begin
      low_run = low_run + 1;
    end else begin
      low_run = 0;
      had_req = 0;
    end
    if (done) done_cnt = done_cnt + 1;
    req_prev = cnt_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge assert_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic rd(input int i, input logic [31:0] exp, input string tag);
    snap_raddr = 4'(i);
    tick();
    chk(tag, snap_rdata, exp);
  endtask

  int abase, dbase, gbase;

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_req",  {31'd0, cnt_req}, 32'd0);
    chk("rst_addr", cnt_addr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_fail", {31'd0, fail_latched}, 32'd0);
    chk("rst_rdata", snap_rdata, 32'd0);
    assert_rst = 1'b0;
    tick();

    // 1: normal sweep, ack 2 cycles after request, data = addr+100
    abase = addr_q.size(); dbase = done_cnt;
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1_idle");
    chk("t1_nreq", addr_q.size() - abase, 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", addr_q[abase+i], 32'(4*i));
    chk("t1_hold1", 32'(hold_q[abase+1]), 32'd3);
    chk("t1_done", done_cnt - dbase, 32'd1);
    chk("t1_terr", {31'd0, timeout_err}, 32'd0);
    rd(0, 32'd100, "t1_snap0");
    rd(1, 32'd104, "t1_snap1");
    rd(2, 32'd108, "t1_snap2");
    rd(3, 32'd112, "t1_snap3");

    // 2: counter at addr 8 never acks -> timeout after 8 cycles
    no_ack_addr = 32'h8;
    abase = addr_q.size(); dbase = done_cnt;
    pulse_start();
    wait_idle("t2_idle");
    chk("t2_nreq", addr_q.size() - abase, 32'd4);
    chk("t2_addr2", addr_q[abase+2], 32'h8);
    chk("t2_hold8", 32'(hold_q[abase+2]), 32'd8);
    chk("t2_done", done_cnt - dbase, 32'd1);
    chk("t2_terr", {31'd0, timeout_err}, 32'd1);
    rd(2, 32'hDEADBEEF, "t2_snap2");
    rd(3, 32'd112, "t2_snap3");
    no_ack_addr = 32'hFFFF_FFFF;

    // 3: rising failure starts a sweep; held/toggled failure adds none
    abase = addr_q.size(); dbase = done_cnt;
    assertion_failed = 1'b1;
    tick();
    chk("t3_busy", {31'd0, busy}, 32'd1);
    chk("t3_req", {31'd0, cnt_req}, 32'd1);
    chk("t3_flat", {31'd0, fail_latched}, 32'd1);
    chk("t3_terr_clr", {31'd0, timeout_err}, 32'd0);
    wait_idle("t3_idle");
    repeat (4) tick();
    chk("t3_nobusy", {31'd0, busy}, 32'd0);
    chk("t3_done", done_cnt - dbase, 32'd1);
    pulse_start();
    repeat (2) tick();
    assertion_failed = 1'b0;
    repeat (2) tick();
    assertion_failed = 1'b1;
    wait_idle("t3_idle2");
    repeat (4) tick();
    chk("t3_nreq", addr_q.size() - abase, 32'd8);
    chk("t3_done2", done_cnt - dbase, 32'd2);
    assertion_failed = 1'b0;
    repeat (3) tick();

    // 4: start and failure rise together -> one sweep
    abase = addr_q.size(); dbase = done_cnt;
    start = 1'b1; assertion_failed = 1'b1;
    tick();
    start = 1'b0; assertion_failed = 1'b0;
    wait_idle("t4_idle");
    repeat (4) tick();
    chk("t4_nreq", addr_q.size() - abase, 32'd4);
    chk("t4_done", done_cnt - dbase, 32'd1);

    // 5: reset while requesting index 1
    data_ofs = 32'd200;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      if (cnt_req && cnt_addr == 32'h4) break;
      tick();
    end
    chk("t5_at_idx1", cnt_addr, 32'h4);
    assert_rst = 1'b1;
    tick();
    chk("t5_req", {31'd0, cnt_req}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_flat", {31'd0, fail_latched}, 32'd0);
    assert_rst = 1'b0;
    tick();
    rd(0, 32'd200, "t5_snap0");
    rd(1, 32'd104, "t5_snap1");

    // 6: immediate acks -> exactly one idle cycle between requests
    ack_delay = 0; data_ofs = 32'd300;
    abase = addr_q.size(); gbase = gap_q.size();
    pulse_start();
    wait_idle("t6_idle");
    chk("t6_nreq", addr_q.size() - abase, 32'd4);
    chk("t6_ngap", gap_q.size() - gbase, 32'd3);
    for (int i = 0; i < 3; i++) chk("t6_gap", 32'(gap_q[gbase+i]), 32'd1);
    chk("t6_hold", 32'(hold_q[abase]), 32'd1);
    for (int i = 0; i < 4; i++) rd(i, 32'(300 + 4*i), "t6_snap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
